// File: rtl/store_commit_buffer_if.sv
// Retire-lane, cache write-port and completion signals of the store commit buffer.
// The master side is the environment; the slave side is the buffer itself.
interface store_commit_buffer_if #(
  parameter int N_WAY = 2,
  parameter int XLEN  = 32,
  parameter int POS_W = 4
);
  localparam int FS_W = $clog2(N_WAY) + 1;

  logic [N_WAY-1:0]       in_valid;
  logic [N_WAY*XLEN-1:0]  in_addr;
  logic [N_WAY*XLEN-1:0]  in_data;
  logic [N_WAY*2-1:0]     in_size;
  logic [N_WAY*POS_W-1:0] in_pos;
  logic [FS_W-1:0]        free_slots;
  logic                   mem_req_valid;
  logic [XLEN-1:0]        mem_req_addr;
  logic [XLEN-1:0]        mem_req_data;
  logic [3:0]             mem_req_be;
  logic                   mem_req_ready;
  logic                   mem_ack;
  logic                   done_valid;
  logic [POS_W-1:0]       done_pos;
  logic                   overflow_err;

  modport master (
    output in_valid, in_addr, in_data, in_size, in_pos, mem_req_ready, mem_ack,
    input  free_slots, mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
           done_valid, done_pos, overflow_err
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_size, in_pos, mem_req_ready, mem_ack,
    output free_slots, mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
           done_valid, done_pos, overflow_err
  );
endinterface

// File: rtl/store_commit_buffer.sv
// In-order buffer between the store queue and the D-cache write port: formats retired
// stores at enqueue, issues one write at a time and reports each completion by SQ slot.
module store_commit_buffer #(
  parameter int N_WAY = 2,
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int POS_W = 4
) (
  input logic                i_clk,
  input logic                i_rst,
  store_commit_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FS_W  = $clog2(N_WAY) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  data;
    logic [3:0]       be;
    logic [POS_W-1:0] pos;
  } entry_t;

  function automatic entry_t fmt_store(input logic [1:0] size, input logic [XLEN-1:0] addr,
                                       input logic [XLEN-1:0] data, input logic [POS_W-1:0] pos);
    entry_t e;
    e.addr = {addr[XLEN-1:2], 2'b00};
    e.pos  = pos;
    case (size)
      2'd0: begin
        e.be   = 4'b0001 << addr[1:0];
        e.data = {(XLEN/8){data[7:0]}};
      end
      2'd1: begin
        e.be   = addr[1] ? 4'b1100 : 4'b0011;
        e.data = {(XLEN/16){data[15:0]}};
      end
      default: begin
        e.be   = 4'b1111;
        e.data = data;
      end
    endcase
    return e;
  endfunction

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  state_t           r_state;
  logic             r_req_valid;
  logic [XLEN-1:0]  r_req_addr;
  logic [XLEN-1:0]  r_req_data;
  logic [3:0]       r_req_be;
  logic [POS_W-1:0] r_req_pos;
  logic             r_done_valid;
  logic [POS_W-1:0] r_done_pos;
  logic             r_ovf;

  entry_t           w_lane [N_WAY];
  entry_t           w_head;
  logic [CNT_W-1:0] w_space;
  logic [FS_W-1:0]  w_free;
  logic [FS_W-1:0]  w_nvalid;
  logic [FS_W-1:0]  w_nacc;
  logic             w_drop;
  logic             w_pop;

  always_comb begin
    for (int i = 0; i < N_WAY; i++) begin
      w_lane[i] = fmt_store(bus.in_size[i*2 +: 2], bus.in_addr[i*XLEN +: XLEN],
                            bus.in_data[i*XLEN +: XLEN], bus.in_pos[i*POS_W +: POS_W]);
    end
  end

  // Free space deliberately ignores a same-cycle pop so it depends on count alone.
  always_comb begin
    w_space = CNT_W'(DEPTH) - r_count;
    w_free  = FS_W'(N_WAY);
    if (w_space < CNT_W'(N_WAY)) w_free = FS_W'(w_space);
    w_nvalid = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (bus.in_valid[i]) w_nvalid = w_nvalid + 1'b1;
    end
    w_drop = (w_nvalid > w_free);
    w_nacc = w_drop ? w_free : w_nvalid;
    w_pop  = (r_state == S_WAIT) && bus.mem_ack;
  end

  // An empty buffer forwards lane 0 so a new store reaches REQ one cycle after its write.
  assign w_head = (r_count == '0) ? w_lane[0] : r_mem[r_head];

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < N_WAY; i++) begin
      if (FS_W'(i) < w_nacc) r_mem[r_tail + PTR_W'(i)] <= w_lane[i];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_state      <= S_IDLE;
      r_req_valid  <= 1'b0;
      r_req_addr   <= '0;
      r_req_data   <= '0;
      r_req_be     <= '0;
      r_req_pos    <= '0;
      r_done_valid <= 1'b0;
      r_done_pos   <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_head       <= r_head + PTR_W'(w_pop);
      r_tail       <= r_tail + PTR_W'(w_nacc);
      r_count      <= r_count + CNT_W'(w_nacc) - CNT_W'(w_pop);
      r_ovf        <= r_ovf | w_drop;
      r_done_valid <= 1'b0;
      r_done_pos   <= '0;
      case (r_state)
        S_IDLE: begin
          if ((r_count != '0) || (w_nacc != '0)) begin
            r_state     <= S_REQ;
            r_req_valid <= 1'b1;
            r_req_addr  <= w_head.addr;
            r_req_data  <= w_head.data;
            r_req_be    <= w_head.be;
            r_req_pos   <= w_head.pos;
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.mem_ack) begin
            r_state      <= S_IDLE;
            r_done_valid <= 1'b1;
            r_done_pos   <= r_req_pos;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.free_slots    = w_free;
  assign bus.mem_req_valid = r_req_valid;
  assign bus.mem_req_addr  = r_req_addr;
  assign bus.mem_req_data  = r_req_data;
  assign bus.mem_req_be    = r_req_be;
  assign bus.done_valid    = r_done_valid;
  assign bus.done_pos      = r_done_pos;
  assign bus.overflow_err  = r_ovf;
endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: format vectors, hand-written corner sequences and
// randomized traffic, all cross-checked against a queue-based store model.
module tb_store_commit_buffer;
  localparam int N_WAY = 2;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int POS_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_commit_buffer_if #(.N_WAY(N_WAY), .XLEN(XLEN), .POS_W(POS_W)) bus ();

  store_commit_buffer #(.N_WAY(N_WAY), .DEPTH(DEPTH), .XLEN(XLEN), .POS_W(POS_W)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [3:0]       be;
    logic [POS_W-1:0] pos;
  } st_t;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    int          pos;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_data;
  } vec_t;

  st_t              mq[$];
  bit               m_out;
  bit               m_done;
  logic [POS_W-1:0] m_done_pos;
  bit               m_ovf;
  int               n_checks = 0;
  int               n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic st_t model_fmt(input logic [1:0] size, input logic [31:0] a,
                                    input logic [31:0] d, input logic [POS_W-1:0] pos);
    st_t s;
    int  off;
    off    = int'(a % 4);
    s.addr = a - 32'(off);
    s.pos  = pos;
    if (size == 2'd0) begin
      s.be   = 4'(1 << off);
      s.data = {4{d[7:0]}};
    end else if (size == 2'd1) begin
      s.be   = (off >= 2) ? 4'hC : 4'h3;
      s.data = {2{d[15:0]}};
    end else begin
      s.be   = 4'hF;
      s.data = d;
    end
    return s;
  endfunction

  // One clock: check outputs against the model at the falling edge, advance the model
  // with the inputs that the next rising edge will see, then return just after that edge.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      chk("rst_free_slots", bus.free_slots, N_WAY);
      chk("rst_req_valid", bus.mem_req_valid, 0);
      chk("rst_done_valid", bus.done_valid, 0);
      chk("rst_overflow", bus.overflow_err, 0);
      mq.delete();
      m_out = 0; m_done = 0; m_ovf = 0;
    end else begin
      int fr, nv, acc;
      fr = DEPTH - mq.size();
      if (fr > N_WAY) fr = N_WAY;
      chk("free_slots", bus.free_slots, fr);
      chk("done_valid", bus.done_valid, m_done);
      chk("done_pos", bus.done_pos, m_done ? m_done_pos : 0);
      chk("overflow_err", bus.overflow_err, m_ovf);
      if (bus.mem_req_valid) begin
        if (mq.size() == 0 || m_out) chk("spurious_req", 1, 0);
        else begin
          chk("req_addr", bus.mem_req_addr, mq[0].addr);
          chk("req_data", bus.mem_req_data, mq[0].data);
          chk("req_be", bus.mem_req_be, mq[0].be);
        end
      end
      m_done = 0;
      if (m_out && bus.mem_ack) begin
        m_done = 1; m_done_pos = mq[0].pos;
        void'(mq.pop_front());
        m_out = 0;
      end else if (bus.mem_req_valid && bus.mem_req_ready) m_out = 1;
      nv  = $countones(bus.in_valid);
      acc = (nv < fr) ? nv : fr;
      if (nv > fr) m_ovf = 1;
      for (int i = 0; i < acc; i++)
        mq.push_back(model_fmt(bus.in_size[i*2 +: 2], bus.in_addr[i*32 +: 32],
                               bus.in_data[i*32 +: 32], bus.in_pos[i*POS_W +: POS_W]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [1:0] size, input logic [31:0] a,
                          input logic [31:0] d, input int pos);
    bus.in_valid[l]              = 1'b1;
    bus.in_size[l*2 +: 2]        = size;
    bus.in_addr[l*32 +: 32]      = a;
    bus.in_data[l*32 +: 32]      = d;
    bus.in_pos[l*POS_W +: POS_W] = POS_W'(pos);
  endtask

  task automatic clear_in();
    bus.in_valid = '0; bus.in_size = '0; bus.in_addr = '0; bus.in_data = '0; bus.in_pos = '0;
  endtask

  // Wait (bounded) for a request, check it, accept it, ack it, then check the done pulse.
  task automatic serve(input string nm, input logic [31:0] ea, input logic [3:0] eb,
                       input logic [31:0] ed, input int epos);
    int n = 0;
    while (!bus.mem_req_valid && n < 20) begin tick(); n++; end
    chk({nm, "_req_seen"}, bus.mem_req_valid, 1);
    chk({nm, "_addr"}, bus.mem_req_addr, ea);
    chk({nm, "_be"}, bus.mem_req_be, eb);
    chk({nm, "_data"}, bus.mem_req_data, ed);
    bus.mem_req_ready = 1'b1; tick(); bus.mem_req_ready = 1'b0;
    chk({nm, "_wait_valid"}, bus.mem_req_valid, 0);
    bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
    chk({nm, "_done_valid"}, bus.done_valid, 1);
    chk({nm, "_done_pos"}, bus.done_pos, epos);
  endtask

  vec_t tbl[8];
  int   got[$];
  int   pos_ctr;

  initial begin
    tbl[0] = '{2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 3, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF};
    tbl[1] = '{2'd0, 32'h0000_0203, 32'h0000_00AB, 1, 32'h0000_0200, 4'h8, 32'hABAB_ABAB};
    tbl[2] = '{2'd1, 32'h0000_0206, 32'h0000_1234, 2, 32'h0000_0204, 4'hC, 32'h1234_1234};
    tbl[3] = '{2'd0, 32'h0000_1000, 32'hFFFF_FF5A, 4, 32'h0000_1000, 4'h1, 32'h5A5A_5A5A};
    tbl[4] = '{2'd1, 32'h0000_0301, 32'h1111_BEEF, 5, 32'h0000_0300, 4'h3, 32'hBEEF_BEEF};
    tbl[5] = '{2'd3, 32'h0000_040B, 32'hCAFE_F00D, 6, 32'h0000_0408, 4'hF, 32'hCAFE_F00D};
    tbl[6] = '{2'd0, 32'h0000_0007, 32'h0000_0012, 7, 32'h0000_0004, 4'h8, 32'h1212_1212};
    tbl[7] = '{2'd0, 32'h0000_0005, 32'h0000_0034, 8, 32'h0000_0004, 4'h2, 32'h3434_3434};

    rst = 1'b1;
    clear_in();
    bus.mem_req_ready = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    chk("reset_free_slots", bus.free_slots, N_WAY);
    chk("reset_req_valid", bus.mem_req_valid, 0);
    chk("reset_done_pos", bus.done_pos, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single stores: formatting and minimum latency (REQ at t+1, done at t+3).
    for (int v = 0; v < 8; v++) begin
      set_lane(0, tbl[v].size, tbl[v].addr, tbl[v].data, tbl[v].pos);
      tick();
      clear_in();
      chk("tbl_req_at_t1", bus.mem_req_valid, 1);
      serve("tbl", tbl[v].e_addr, tbl[v].e_be, tbl[v].e_data, tbl[v].pos);
      tick();
    end

    // Two lanes in one cycle complete in lane order.
    set_lane(0, 2'd0, 32'h203, 32'hAB, 1);
    set_lane(1, 2'd1, 32'h206, 32'h1234, 2);
    tick();
    clear_in();
    serve("two_l0", 32'h200, 4'h8, 32'hABAB_ABAB, 1);
    serve("two_l1", 32'h204, 4'hC, 32'h1234_1234, 2);
    tick();

    // Request held while the cache is not ready.
    set_lane(0, 2'd2, 32'h400, 32'h1122_3344, 5);
    tick();
    clear_in();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", bus.mem_req_valid, 1);
      chk("stall_addr", bus.mem_req_addr, 32'h400);
      chk("stall_data", bus.mem_req_data, 32'h1122_3344);
      chk("stall_no_done", bus.done_valid, 0);
      tick();
    end
    serve("stall", 32'h400, 4'hF, 32'h1122_3344, 5);
    tick();

    // Fill to DEPTH, then overflow.
    set_lane(0, 2'd2, 32'h500, 32'h0, 6); set_lane(1, 2'd2, 32'h504, 32'h1, 7);
    tick();
    set_lane(0, 2'd2, 32'h508, 32'h2, 8); set_lane(1, 2'd2, 32'h50C, 32'h3, 9);
    tick();
    clear_in();
    chk("full_free_slots", bus.free_slots, 0);
    chk("full_no_ovf", bus.overflow_err, 0);
    set_lane(0, 2'd2, 32'h510, 32'h4, 10); set_lane(1, 2'd2, 32'h514, 32'h5, 11);
    tick();
    clear_in();
    chk("ovf_set", bus.overflow_err, 1);
    chk("ovf_free_slots", bus.free_slots, 0);
    for (int k = 0; k < 4; k++) serve("fill", 32'h500 + 32'(4*k), 4'hF, 32'(k), 6 + k);
    tick(); tick();
    chk("ovf_sticky", bus.overflow_err, 1);

    // Reset while a write is outstanding with three stores queued.
    bus.mem_req_ready = 1'b0;
    set_lane(0, 2'd2, 32'h600, 32'hA, 1); set_lane(1, 2'd2, 32'h604, 32'hB, 2);
    tick();
    set_lane(0, 2'd2, 32'h608, 32'hC, 3); bus.in_valid[1] = 1'b0;
    tick();
    clear_in();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    chk("pre_rst_in_wait", bus.mem_req_valid, 0);
    rst = 1'b1;
    #1;
    chk("midrst_free_slots", bus.free_slots, N_WAY);
    chk("midrst_req_valid", bus.mem_req_valid, 0);
    chk("midrst_addr", bus.mem_req_addr, 0);
    chk("midrst_done_valid", bus.done_valid, 0);
    chk("midrst_overflow", bus.overflow_err, 0);
    tick();
    rst = 1'b0;
    bus.mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("postrst_no_done", bus.done_valid, 0);
      chk("postrst_no_req", bus.mem_req_valid, 0);
    end
    bus.mem_ack = 1'b0;

    // Streaming across the pointer wrap with pushes overlapping pops.
    bus.mem_req_ready = 1'b1;
    bus.mem_ack = 1'b1;
    got.delete();
    pos_ctr = 1;
    for (int c = 0; c < 120 && got.size() < 10; c++) begin
      clear_in();
      if (pos_ctr <= 10 && bus.free_slots != 0 && (c % 2 == 0)) begin
        set_lane(0, 2'd2, 32'h700 + 32'(4*pos_ctr), 32'(pos_ctr), pos_ctr);
        pos_ctr++;
      end
      tick();
      if (bus.done_valid) got.push_back(int'(bus.done_pos));
    end
    clear_in();
    chk("wrap_done_count", got.size(), 10);
    for (int k = 0; k < got.size(); k++) chk("wrap_done_order", got[k], k + 1);
    tick(); tick();

    // Randomized traffic, including overflow and ignored acks.
    pos_ctr = 1;
    for (int c = 0; c < 600; c++) begin
      int nv;
      clear_in();
      nv = int'($urandom_range(0, 2));
      for (int l = 0; l < nv; l++) begin
        set_lane(l, 2'($urandom_range(0, 3)), $urandom, $urandom, pos_ctr);
        pos_ctr = (pos_ctr == 15) ? 1 : pos_ctr + 1;
      end
      bus.mem_req_ready = 1'($urandom_range(0, 1));
      bus.mem_ack = 1'($urandom_range(0, 1));
      tick();
    end
    clear_in();
    bus.mem_req_ready = 1'b1;
    bus.mem_ack = 1'b1;
    for (int c = 0; c < 200 && (mq.size() != 0 || m_done); c++) tick();
    chk("random_drained", mq.size(), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
